// File: rtl/csr_split_gen.sv
// Streams one N-lane chunk of CSR reduction controls per cycle from a latched row-pointer vector.
// Chunk outputs are decoded combinationally from the registered pointers and chunk counter.
module csr_split_gen #(
    parameter int N     = 16,
    parameter int LGN   = $clog2(N),
    parameter int DBLGN = 2 * $clog2(N)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       lhs_start,
    input  logic [N-1:0][DBLGN-1:0]    lhs_ptr,
    output logic                       lhs_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_split,
    output logic [N-1:0][LGN-1:0]      out_idx,
    output logic [N-1:0]               lane_valid,
    output logic [DBLGN-1:0]           chunk_idx,
    output logic                       out_last,
    output logic [N-1:0]               empty_rows
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    logic [N-1:0][DBLGN-1:0]   ptr;
    logic [LGN-1:0]            cnt;
    logic [LGN-1:0]            last_c;
    logic [N-1:0]              row_ne;

    // Index of the final chunk: ceil(nnz/N)-1, with nnz=0 still producing one chunk.
    // N is a power of two, so the top LGN bits of nnz-1 give the chunk number.
    function automatic logic [LGN-1:0] last_chunk(input logic [DBLGN-1:0] nnz);
        logic [DBLGN-1:0] m1;
        m1 = nnz - {{(DBLGN-1){1'b0}}, 1'b1};
        if (nnz == '0)
            return '0;
        return m1[DBLGN-1:LGN];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            last_c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lhs_start) begin
                        ptr    <= lhs_ptr;
                        last_c <= last_chunk(lhs_ptr[N-1]);
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == last_c) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lhs_ready = (state == IDLE);
    assign out_valid = (state == RUN);

    always_comb begin
        row_ne    = '0;
        row_ne[0] = (ptr[0] != '0);
        for (int r = 1; r < N; r++)
            row_ne[r] = (ptr[r] > ptr[r-1]);
    end

    always_comb begin
        logic [DBLGN:0] k;
        logic [DBLGN:0] row_end;
        out_split  = '0;
        out_idx    = '0;
        lane_valid = '0;
        chunk_idx  = '0;
        out_last   = 1'b0;
        empty_rows = '0;
        k          = '0;
        row_end    = '0;
        if (out_valid) begin
            chunk_idx  = {{(DBLGN-LGN){1'b0}}, cnt};
            out_last   = (cnt == last_c);
            empty_rows = ~row_ne;
            for (int j = 0; j < N; j++) begin
                k = {1'b0, cnt, LGN'(j)};
                lane_valid[j] = (k < {1'b0, ptr[N-1]});
                // Scan rows high to low so the smallest matching row wins.
                for (int r = N - 1; r >= 0; r--) begin
                    row_end = {1'b0, ptr[r]} - {{DBLGN{1'b0}}, 1'b1};
                    if (row_ne[r] && (row_end == k)) begin
                        out_split[j] = 1'b1;
                        out_idx[j]   = LGN'(r);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_split_gen.sv
// Bench for csr_split_gen: an N=4 and an N=16 instance checked every cycle against a chunk-queue model.
module tb_csr_split_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start4, start16;
    logic [3:0][3:0]   ptr4;
    logic [15:0][7:0]  ptr16;

    logic              ready4, valid4, last4;
    logic [3:0]        split4, lv4, empty4, cidx4;
    logic [3:0][1:0]   idx4;

    logic              ready16, valid16, last16;
    logic [15:0]       split16, lv16, empty16;
    logic [15:0][3:0]  idx16;
    logic [7:0]        cidx16;

    csr_split_gen #(.N(4)) dut4 (
        .clock(clk), .reset(rst), .lhs_start(start4), .lhs_ptr(ptr4),
        .lhs_ready(ready4), .out_valid(valid4), .out_split(split4), .out_idx(idx4),
        .lane_valid(lv4), .chunk_idx(cidx4), .out_last(last4), .empty_rows(empty4)
    );

    csr_split_gen #(.N(16)) dut16 (
        .clock(clk), .reset(rst), .lhs_start(start16), .lhs_ptr(ptr16),
        .lhs_ready(ready16), .out_valid(valid16), .out_split(split16), .out_idx(idx16),
        .lane_valid(lv16), .chunk_idx(cidx16), .out_last(last16), .empty_rows(empty16)
    );

    typedef struct packed {
        logic [15:0]      split;
        logic [15:0][3:0] idx;
        logic [15:0]      lv;
        logic [7:0]       cidx;
        logic             last;
        logic [15:0]      empty;
    } chunk_t;

    chunk_t q4[$];
    chunk_t q16[$];
    int     n_chk = 0;
    int     n_fail = 0;
    bit     after_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int nchunks(input int n, input int nnz);
        return (nnz == 0) ? 1 : (nnz + n - 1) / n;
    endfunction

    // Expected chunk c: mark each non-empty row's last nonzero position, keeping the smallest row.
    function automatic chunk_t model_chunk(input int n, input int p[16], input int c);
        chunk_t ch;
        int nnz, st, e;
        ch  = '0;
        nnz = p[n-1];
        for (int j = 0; j < n; j++)
            ch.lv[j] = (c * n + j < nnz);
        for (int r = 0; r < n; r++) begin
            st = (r == 0) ? 0 : p[r-1];
            ch.empty[r] = !(p[r] > st);
            if (p[r] > st) begin
                e = p[r] - 1;
                if (e >= c * n && e < c * n + n && !ch.split[e - c * n]) begin
                    ch.split[e - c * n] = 1'b1;
                    ch.idx[e - c * n]   = 4'(r);
                end
            end
        end
        ch.cidx = 8'(c);
        ch.last = (c == nchunks(n, nnz) - 1);
        return ch;
    endfunction

    function automatic logic [63:0] pack_idx(input chunk_t ch, input int n, input int lgn);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < n; j++)
            for (int b = 0; b < lgn; b++)
                v[j * lgn + b] = ch.idx[j][b];
        return v;
    endfunction

    task automatic cmp_dut(input string tag, input bit busy, input bit zero_chk, input chunk_t e,
                           input int n, input int lgn, input logic rdy, input logic vld,
                           input logic [15:0] sp, input logic [63:0] ix, input logic [15:0] lv,
                           input logic [7:0] ci, input logic lst, input logic [15:0] em);
        chk({tag, ".ready"}, 64'(rdy), 64'(!busy));
        chk({tag, ".valid"}, 64'(vld), 64'(busy));
        if (busy || zero_chk) begin
            chk({tag, ".split"}, 64'(sp), busy ? 64'(e.split) : 64'd0);
            chk({tag, ".idx"},   ix,      busy ? pack_idx(e, n, lgn) : 64'd0);
            chk({tag, ".lane_valid"}, 64'(lv), busy ? 64'(e.lv) : 64'd0);
            chk({tag, ".chunk_idx"},  64'(ci), busy ? 64'(e.cidx) : 64'd0);
            chk({tag, ".last"},  64'(lst), busy ? 64'(e.last) : 64'd0);
            chk({tag, ".empty_rows"}, 64'(em), busy ? 64'(e.empty) : 64'd0);
        end
    endtask

    // Compare current outputs, then advance the model with the inputs the next edge will sample.
    always @(negedge clk) begin : compare
        chunk_t e4, e16;
        int     p[16];
        e4  = (q4.size()  != 0) ? q4[0]  : '0;
        e16 = (q16.size() != 0) ? q16[0] : '0;
        cmp_dut("n4",  q4.size() != 0,  after_rst, e4,  4,  2, ready4, valid4,
                16'(split4), 64'(idx4), 16'(lv4), 8'(cidx4), last4, 16'(empty4));
        cmp_dut("n16", q16.size() != 0, after_rst, e16, 16, 4, ready16, valid16,
                split16, 64'(idx16), lv16, cidx16, last16, empty16);
        if (rst) begin
            q4.delete();
            q16.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (q4.size() != 0) begin
                void'(q4.pop_front());
            end else if (start4) begin
                p = '{default: 0};
                for (int r = 0; r < 4; r++) p[r] = int'(ptr4[r]);
                for (int c = 0; c < nchunks(4, p[3]); c++) q4.push_back(model_chunk(4, p, c));
            end
            if (q16.size() != 0) begin
                void'(q16.pop_front());
            end else if (start16) begin
                for (int r = 0; r < 16; r++) p[r] = int'(ptr16[r]);
                for (int c = 0; c < nchunks(16, p[15]); c++) q16.push_back(model_chunk(16, p, c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go4(input logic [3:0][3:0] p);
        ptr4   = p;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (q4.size() == 0 && q16.size() == 0) break;
            tick();
        end
        chk("drain", 64'(q4.size() + q16.size()), 64'd0);
    endtask

    task automatic rand_ptr4();
        int v;
        v = 0;
        for (int r = 0; r < 4; r++) begin
            v += int'($urandom_range(0, 5));
            if (v > 15) v = 15;
            ptr4[r] = 4'(v);
        end
    endtask

    task automatic rand_ptr16();
        int v;
        v = 0;
        for (int r = 0; r < 16; r++) begin
            v += ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 24));
            if (v > 255) v = 255;
            ptr16[r] = 8'(v);
        end
    endtask

    initial begin
        rst = 1'b1; start4 = 1'b0; start16 = 1'b0; ptr4 = '0; ptr16 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // ptr = {2,2,5,7}: two chunks
        go4({4'd7, 4'd5, 4'd2, 4'd2});
        #2;
        chk("t1c0.split", 64'(split4), 64'h2);
        chk("t1c0.lane_valid", 64'(lv4), 64'hF);
        chk("t1c0.empty", 64'(empty4), 64'h2);
        chk("t1c0.last", 64'(last4), 64'd0);
        tick();
        #2;
        chk("t1c1.split", 64'(split4), 64'h5);
        chk("t1c1.idx", 64'(idx4), 64'h32);
        chk("t1c1.lane_valid", 64'(lv4), 64'h7);
        chk("t1c1.last", 64'(last4), 64'd1);
        wait_idle();

        // ptr = {4,8,12,15}: four chunks, inspect the final one
        go4({4'd15, 4'd12, 4'd8, 4'd4});
        repeat (3) tick();
        #2;
        chk("t2c3.split", 64'(split4), 64'h4);
        chk("t2c3.idx2", 64'(idx4[2]), 64'd3);
        chk("t2c3.lane_valid", 64'(lv4), 64'h7);
        chk("t2c3.chunk_idx", 64'(cidx4), 64'd3);
        wait_idle();

        // all-zero ptr: a single empty chunk
        go4('0);
        #2;
        chk("t3.last", 64'(last4), 64'd1);
        chk("t3.split", 64'(split4), 64'd0);
        chk("t3.lane_valid", 64'(lv4), 64'd0);
        chk("t3.empty", 64'(empty4), 64'hF);
        wait_idle();

        // start held high through a stream: only the first and the post-idle starts are taken
        go4({4'd15, 4'd12, 4'd8, 4'd4});
        for (int i = 0; i < 5; i++) begin
            rand_ptr4();
            start4 = 1'b1;
            tick();
        end
        start4 = 1'b0;
        wait_idle();

        // reset during chunk 1 aborts the stream
        go4({4'd15, 4'd12, 4'd8, 4'd4});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("t5.valid", 64'(valid4), 64'd0);
        chk("t5.ready", 64'(ready4), 64'd1);
        go4({4'd7, 4'd5, 4'd2, 4'd2});
        #2;
        chk("t5.restart_cidx", 64'(cidx4), 64'd0);
        chk("t5.restart_split", 64'(split4), 64'h2);
        wait_idle();

        // N=16 staircase, nnz = 255
        for (int r = 0; r < 16; r++) ptr16[r] = 8'(16 * (r + 1) - 1);
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (15) tick();
        #2;
        chk("t6.last", 64'(last16), 64'd1);
        chk("t6.chunk_idx", 64'(cidx16), 64'd15);
        chk("t6.lane_valid", 64'(lv16), 64'h7FFF);
        chk("t6.split", 64'(split16), 64'h4000);
        chk("t6.idx14", 64'(idx16[14]), 64'd15);
        wait_idle();

        // randomized monotonic pointer vectors on both instances
        for (int t = 0; t < 30; t++) begin
            rand_ptr4();
            rand_ptr16();
            start4  = 1'b1;
            start16 = 1'b1;
            tick();
            start4  = 1'b0;
            start16 = 1'b0;
            wait_idle();
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
